// File: rtl/binarization_output.sv
// rtl/binarization_output.sv - bipolar popcount accumulator with scaled, saturated multi-bit output
module binarization_output #(
    parameter int KERNEL_SIZE = 9,
    parameter int CHANNEL_CNT = 8,
    parameter int BIT_WIDTH   = 8,
    parameter int BEATS       = 4,
    parameter int SHIFT       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [KERNEL_SIZE*CHANNEL_CNT-1:0] in_bits,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [KERNEL_SIZE*BIT_WIDTH-1:0] out_value,
    output logic [KERNEL_SIZE-1:0]           out_sat
);

    localparam int AW  = $clog2(CHANNEL_CNT * BEATS) + 2;
    localparam int CW  = ((AW > BIT_WIDTH) ? AW : BIT_WIDTH) + 1;
    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0]       LAST_BEAT = BCW'(BEATS - 1);
    localparam logic signed [CW-1:0] SAT_MAX   = CW'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_MIN   = CW'(-(2 ** (BIT_WIDTH - 1)));

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state, state_next;
    logic [BCW-1:0]        beat_cnt;
    logic signed [AW-1:0]  acc [KERNEL_SIZE];
    logic signed [AW-1:0]  sum [KERNEL_SIZE];
    logic [AW-1:0]         pop;
    logic signed [CW-1:0]  scaled;
    logic [KERNEL_SIZE*BIT_WIDTH-1:0] clip_value;
    logic [KERNEL_SIZE-1:0]           clip_sat;
    logic                  last_beat, accept, final_accept;

    assign last_beat    = (beat_cnt == LAST_BEAT);
    // Only the frame-closing beat needs the output register, so only it waits on the consumer.
    assign in_ready     = !rst && !(last_beat && out_valid && !out_ready);
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && last_beat;
    assign out_valid    = (state == FULL);

    always_comb begin
        pop        = '0;
        scaled     = '0;
        clip_value = '0;
        clip_sat   = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            pop = '0;
            for (int j = 0; j < CHANNEL_CNT; j++) begin
                pop = pop + AW'(in_bits[i*CHANNEL_CNT + j]);
            end
            sum[i] = acc[i] + (pop << 1) - AW'(CHANNEL_CNT);
            scaled = CW'(sum[i]) >>> SHIFT;
            if (scaled > SAT_MAX) begin
                clip_value[i*BIT_WIDTH +: BIT_WIDTH] = SAT_MAX[BIT_WIDTH-1:0];
                clip_sat[i] = 1'b1;
            end else if (scaled < SAT_MIN) begin
                clip_value[i*BIT_WIDTH +: BIT_WIDTH] = SAT_MIN[BIT_WIDTH-1:0];
                clip_sat[i] = 1'b1;
            end else begin
                clip_value[i*BIT_WIDTH +: BIT_WIDTH] = scaled[BIT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (final_accept) state_next = FULL;
            FULL:  if (out_ready && !final_accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            beat_cnt  <= '0;
            out_value <= '0;
            out_sat   <= '0;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                acc[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                for (int i = 0; i < KERNEL_SIZE; i++) begin
                    acc[i] <= last_beat ? '0 : sum[i];
                end
            end
            if (final_accept) begin
                out_value <= clip_value;
                out_sat   <= clip_sat;
            end
        end
    end

endmodule

// File: tb/tb_binarization_output.sv
// tb/tb_binarization_output.sv - directed self-checking bench for binarization_output
module tb_binarization_output;

    localparam logic [71:0] ONES  = '1;
    localparam logic [71:0] ZEROS = '0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [71:0] in_bits;
    logic        out_ready;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        ov0, ov1, ov2, ov3;
    logic [71:0] val0, val3;
    logic [53:0] val1, val2;
    logic [8:0]  sat0, sat1, sat2, sat3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    binarization_output d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_bits(in_bits),
        .out_valid(ov0), .out_ready(out_ready), .out_value(val0), .out_sat(sat0)
    );
    binarization_output #(.BIT_WIDTH(6), .SHIFT(0)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_bits(in_bits),
        .out_valid(ov1), .out_ready(out_ready), .out_value(val1), .out_sat(sat1)
    );
    binarization_output #(.BIT_WIDTH(6), .SHIFT(1)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_bits(in_bits),
        .out_valid(ov2), .out_ready(out_ready), .out_value(val2), .out_sat(sat2)
    );
    binarization_output #(.BEATS(1)) d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_bits(in_bits),
        .out_valid(ov3), .out_ready(out_ready), .out_value(val3), .out_sat(sat3)
    );

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic beat(input logic [71:0] bits);
        in_valid = 1'b1;
        in_bits  = bits;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_bits = ZEROS;
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ov0); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rdy0); end
        total++; if (val0 !== 72'h0) begin bad++; $display("FAIL reset_value got=%h want=0", val0); end
        total++; if (sat0 !== 9'h0) begin bad++; $display("FAIL reset_sat got=%h want=0", sat0); end
        rst = 1'b0;
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", rdy0); end
    endtask

    task automatic test_all_ones();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            beat(ONES);
            if (b < 3) begin
                total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL ones_early beat=%0d got=%b want=0", b, ov0); end
            end
        end
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL ones_valid got=%b want=1", ov0); end
        total++; if (val0 !== {9{8'h20}}) begin bad++; $display("FAIL ones_value got=%h want=%h", val0, {9{8'h20}}); end
        total++; if (sat0 !== 9'h0) begin bad++; $display("FAIL ones_sat got=%h want=0", sat0); end
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL ones_drain got=%b want=0", ov0); end
    endtask

    task automatic test_mixed();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) beat({{7{8'hFF}}, 8'h00, 8'h0F});
        total++; if (val0 !== {{7{8'h20}}, 8'hE0, 8'h00}) begin
            bad++; $display("FAIL mixed_value got=%h want=%h", val0, {{7{8'h20}}, 8'hE0, 8'h00});
        end
        total++; if (sat0 !== 9'h0) begin bad++; $display("FAIL mixed_sat got=%h want=0", sat0); end
    endtask

    task automatic test_shift_sat();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) beat(ONES);
        total++; if (val1 !== {9{6'h1F}}) begin bad++; $display("FAIL sat_pos_value got=%h want=%h", val1, {9{6'h1F}}); end
        total++; if (sat1 !== 9'h1FF) begin bad++; $display("FAIL sat_pos_flag got=%h want=1ff", sat1); end
        total++; if (val2 !== {9{6'h10}}) begin bad++; $display("FAIL shift_pos_value got=%h want=%h", val2, {9{6'h10}}); end
        total++; if (sat2 !== 9'h0) begin bad++; $display("FAIL shift_pos_sat got=%h want=0", sat2); end
        for (int b = 0; b < 4; b++) beat(ZEROS);
        total++; if (val1 !== {9{6'h20}}) begin bad++; $display("FAIL sat_min_value got=%h want=%h", val1, {9{6'h20}}); end
        total++; if (sat1 !== 9'h0) begin bad++; $display("FAIL sat_min_flag got=%h want=0", sat1); end
        total++; if (val2 !== {9{6'h30}}) begin bad++; $display("FAIL shift_neg_value got=%h want=%h", val2, {9{6'h30}}); end
        total++; if (sat2 !== 9'h0) begin bad++; $display("FAIL shift_neg_sat got=%h want=0", sat2); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) beat(ONES);
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL bp_a_valid got=%b want=1", ov0); end
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_bits  = ZEROS;
            #1;
            total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_nonfinal_ready beat=%0d got=%b want=1", b, rdy0); end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b want=0", rdy0); end
        @(posedge clk);
        @(negedge clk);
        total++; if (val0 !== {9{8'h20}}) begin bad++; $display("FAIL bp_hold got=%h want=%h", val0, {9{8'h20}}); end
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", ov0); end
        out_ready = 1'b1;
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", rdy0); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL bp_b_valid got=%b want=1", ov0); end
        total++; if (val0 !== {9{8'hE0}}) begin bad++; $display("FAIL bp_b_value got=%h want=%h", val0, {9{8'hE0}}); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", ov0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_bits = (k % 2 == 0) ? ONES : ZEROS;
            #1;
            total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want=1", k, rdy3); end
            @(posedge clk);
            @(negedge clk);
            total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%b want=1", k, ov3); end
            if (k % 2 == 0) begin
                total++; if (val3 !== {9{8'h08}}) begin bad++; $display("FAIL b2b_pos k=%0d got=%h want=%h", k, val3, {9{8'h08}}); end
            end else begin
                total++; if (val3 !== {9{8'hF8}}) begin bad++; $display("FAIL b2b_neg k=%0d got=%h want=%h", k, val3, {9{8'hF8}}); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) beat(ONES);
        for (int b = 0; b < 2; b++) beat(ONES);
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b want=1", ov0); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", ov0); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL mid_async_ready got=%b want=0", rdy0); end
        total++; if (val0 !== 72'h0) begin bad++; $display("FAIL mid_async_value got=%h want=0", val0); end
        #1;
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) beat(ZEROS);
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL mid_no_residue_valid got=%b want=0", ov0); end
        beat(ZEROS);
        total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b want=1", ov0); end
        total++; if (val0 !== {9{8'hE0}}) begin bad++; $display("FAIL mid_value got=%h want=%h", val0, {9{8'hE0}}); end
        total++; if (sat0 !== 9'h0) begin bad++; $display("FAIL mid_sat got=%h want=0", sat0); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_mixed();
        test_shift_sat();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
